debug_clk_ctrl: RTL and testbench

DEBUG_CLK_CTRL -- requirements
Module: debug_clk_ctrl

---
 rtl/debug_clk_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_debug_clk_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/debug_clk_ctrl.sv
// -----------------------------------------------------------------------------
// debug_clk_ctrl
//   Debug clock controller for a soft CPU. Produces a one-cycle CPU clock
//   enable (never a gated clock). The enable can run every cycle, on a divided
//   tick, or once per debounced push-button step. A display mux shows one of
//   CH_N data channels.
//
//   Optional feature: define DBG_BRK_EN to build the PC breakpoint logic.
//   Without it BrkAddrIn/BrkEnIn are ignored and the BRK state is unreachable.
//
// Ports
//   clkIn        system clock, all state on rising edge
//   resetIn      synchronous active-high reset
//   ModeIn       00 halt, 01 full speed, 10 divided, 11 single-step
//   DivSelIn     divider tap index (clamped to DIV_W-1)
//   StepBtnIn    raw asynchronous step button
//   PCIn         current CPU PC
//   BrkAddrIn    breakpoint address
//   BrkEnIn      breakpoint enable
//   ChSelIn      display channel select
//   ChDataIn     packed display channels, channel k at [k*DATA_W +: DATA_W]
//   CpuEnOut     registered one-cycle CPU enable pulse
//   HaltedOut    registered, high in HALT or BRK
//   StepCntOut   count of issued CpuEnOut pulses (wraps)
//   DispDataOut  registered selected channel, 0 when ChSelIn >= CH_N
// -----------------------------------------------------------------------------
module debug_clk_ctrl #(
    parameter int DIV_W  = 25,
    parameter int CH_N   = 4,
    parameter int DATA_W = 32,
    parameter int DBNC_W = 20
) (
    input  logic                      clkIn,
    input  logic                      resetIn,
    input  logic [1:0]                ModeIn,
    input  logic [4:0]                DivSelIn,
    input  logic                      StepBtnIn,
    input  logic [31:0]               PCIn,
    input  logic [31:0]               BrkAddrIn,
    input  logic                      BrkEnIn,
    input  logic [$clog2(CH_N)-1:0]   ChSelIn,
    input  logic [CH_N*DATA_W-1:0]    ChDataIn,
    output logic                      CpuEnOut,
    output logic                      HaltedOut,
    output logic [15:0]               StepCntOut,
    output logic [DATA_W-1:0]         DispDataOut
);

    localparam int          TAP_W   = $clog2(DIV_W);
    localparam int unsigned DIV_MAX = DIV_W - 1;
    localparam int          CSW     = $clog2(CH_N);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_BRK  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Free-running divider and tap edge detect
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic             tap_prev_q;
    logic [TAP_W-1:0] tap_idx;
    logic             tap_bit;
    logic             tick;

    always_comb begin
        if (32'(DivSelIn) > DIV_MAX) tap_idx = TAP_W'(DIV_MAX);
        else                         tap_idx = TAP_W'(DivSelIn);
    end

    assign tap_bit = div_q[tap_idx];
    // A tap change can produce one early tick; harmless for a debug clock.
    assign tick    = tap_bit & ~tap_prev_q;

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            div_q      <= '0;
            tap_prev_q <= 1'b0;
        end else begin
            div_q      <= div_q + DIV_W'(1);
            tap_prev_q <= tap_bit;
        end
    end

    // ------------------------------------------------------------------
    // Step button: 2-flop synchroniser, debounce, rising-edge request
    // ------------------------------------------------------------------
    logic [1:0]        sync_q;
    logic              dbnc_lvl_q;
    logic [DBNC_W-1:0] dbnc_cnt_q;
    logic              step_req_q;
    logic              dbnc_diff;
    logic              dbnc_done;

    assign dbnc_diff = sync_q[1] ^ dbnc_lvl_q;
    // The counter saturating while still different marks the 2^DBNC_W-th
    // consecutive differing cycle, so the level flips on this edge.
    assign dbnc_done = dbnc_diff & (&dbnc_cnt_q);

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            sync_q     <= '0;
            dbnc_lvl_q <= 1'b0;
            dbnc_cnt_q <= '0;
            step_req_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], StepBtnIn};
            if (!dbnc_diff) begin
                dbnc_cnt_q <= '0;
            end else if (dbnc_done) begin
                dbnc_cnt_q <= '0;
                dbnc_lvl_q <= ~dbnc_lvl_q;
            end else begin
                dbnc_cnt_q <= dbnc_cnt_q + DBNC_W'(1);
            end
            step_req_q <= dbnc_done & ~dbnc_lvl_q;
        end
    end

    // ------------------------------------------------------------------
    // Run-control FSM
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [1:0]  mode_q;
    logic        en_q, en_d;
    logic        halted_q;
    logic [15:0] step_cnt_q;
    logic        hit_d;

`ifdef DBG_BRK_EN
    logic armed_q;
    assign hit_d = BrkEnIn & armed_q & (PCIn == BrkAddrIn) & (state_q == S_RUN);

    // Cleared on a hit, re-armed as soon as the PC moves off the address,
    // so resuming at the breakpoint does not immediately re-trap.
    always_ff @(posedge clkIn) begin
        if (resetIn)                armed_q <= 1'b1;
        else if (hit_d)             armed_q <= 1'b0;
        else if (PCIn != BrkAddrIn) armed_q <= 1'b1;
    end
`else
    logic unused_brk;
    assign unused_brk = ^{PCIn, BrkAddrIn, BrkEnIn};
    assign hit_d      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        en_d    = 1'b0;
        case (state_q)
            S_HALT: begin
                if (ModeIn != 2'b00) state_d = S_RUN;
            end
            S_RUN: begin
                if (ModeIn == 2'b00) begin
                    state_d = S_HALT;
                end else if (hit_d) begin
                    state_d = S_BRK;
                end else begin
                    case (ModeIn)
                        2'b01:   en_d = 1'b1;
                        2'b10:   en_d = tick;
                        2'b11:   en_d = step_req_q;
                        default: en_d = 1'b0;
                    endcase
                end
            end
            S_BRK: begin
                en_d = step_req_q;
                if (ModeIn != mode_q) state_d = (ModeIn == 2'b00) ? S_HALT : S_RUN;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state_q    <= S_HALT;
            mode_q     <= 2'b00;
            en_q       <= 1'b0;
            halted_q   <= 1'b1;
            step_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= ModeIn;
            en_q     <= en_d;
            halted_q <= (state_d != S_RUN);
            if (en_d) step_cnt_q <= step_cnt_q + 16'd1;
        end
    end

    assign CpuEnOut   = en_q;
    assign HaltedOut  = halted_q;
    assign StepCntOut = step_cnt_q;

    // ------------------------------------------------------------------
    // Display mux
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] disp_q, disp_d;

    always_comb begin
        disp_d = '0;
        for (int k = 0; k < CH_N; k++) begin
            if (ChSelIn == CSW'(k)) disp_d = ChDataIn[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clkIn) begin
        if (resetIn) disp_q <= '0;
        else         disp_q <= disp_d;
    end

    assign DispDataOut = disp_q;

endmodule

// File: tb/tb_debug_clk_ctrl.sv
module tb_debug_clk_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, btn, brk_en;
    logic [1:0]  mode;
    logic [4:0]  dsel;
    logic [31:0] pc, brk_addr;
    logic [1:0]  chsel;
    logic [127:0] chdata;
    wire         en, halted;
    wire [15:0]  cnt;
    wire [31:0]  disp;

    logic [1:0]  chsel3;
    logic [95:0] chdata3;
    wire         en3, halted3;
    wire [15:0]  cnt3;
    wire [31:0]  disp3;

    int checks = 0;
    int errors = 0;

    debug_clk_ctrl #(.DIV_W(8), .CH_N(4), .DATA_W(32), .DBNC_W(4)) u_dut (
        .clkIn(clk), .resetIn(rst), .ModeIn(mode), .DivSelIn(dsel),
        .StepBtnIn(btn), .PCIn(pc), .BrkAddrIn(brk_addr), .BrkEnIn(brk_en),
        .ChSelIn(chsel), .ChDataIn(chdata), .CpuEnOut(en), .HaltedOut(halted),
        .StepCntOut(cnt), .DispDataOut(disp)
    );

    debug_clk_ctrl #(.DIV_W(8), .CH_N(3), .DATA_W(32), .DBNC_W(4)) u_dut3 (
        .clkIn(clk), .resetIn(rst), .ModeIn(2'b00), .DivSelIn(5'd0),
        .StepBtnIn(1'b0), .PCIn(32'd0), .BrkAddrIn(32'd0), .BrkEnIn(1'b0),
        .ChSelIn(chsel3), .ChDataIn(chdata3), .CpuEnOut(en3), .HaltedOut(halted3),
        .StepCntOut(cnt3), .DispDataOut(disp3)
    );

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Advance until CpuEnOut is seen high; n = cycles taken (limit on timeout).
    task automatic wait_pulse(input int limit, output int n);
        n = 0;
        do begin cyc(1); n++; end while (!en && n < limit);
    endtask

    task automatic test_reset;
        rst = 1; mode = 2'b01; dsel = 0; btn = 0; pc = 0; brk_addr = 32'h10; brk_en = 0;
        chsel = 2'd2; chdata = {32'hCAFEF00D, 32'hDEADBEEF, 32'h89ABCDEF, 32'h01234567};
        chsel3 = 2'd0; chdata3 = {32'h33333333, 32'h22222222, 32'h11111111};
        cyc(2);
        checks++; if (en !== 1'b0)     begin errors++; $display("FAIL rst_en: got %b exp 0", en); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL rst_halted: got %b exp 1", halted); end
        checks++; if (cnt !== 16'd0)   begin errors++; $display("FAIL rst_cnt: got %h exp 0", cnt); end
        checks++; if (disp !== 32'd0)  begin errors++; $display("FAIL rst_disp: got %h exp 0", disp); end
        checks++; if (disp3 !== 32'd0) begin errors++; $display("FAIL rst_disp3: got %h exp 0", disp3); end
    endtask

    task automatic test_full_speed;
        rst = 0;
        cyc(1);
        checks++; if (en !== 1'b0)     begin errors++; $display("FAIL fs_first_en: got %b exp 0", en); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL fs_halted: got %b exp 0", halted); end
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            checks++; if (en !== 1'b1) begin errors++; $display("FAIL fs_en[%0d]: got %b exp 1", i, en); end
        end
        checks++; if (cnt !== 16'd10) begin errors++; $display("FAIL fs_cnt: got %0d exp 10", cnt); end
    endtask

    task automatic test_divided;
        int n;
        int sel[3]    = '{2, 0, 31};
        int period[3] = '{8, 2, 256};
        mode = 2'b10;
        for (int i = 0; i < 3; i++) begin
            dsel = 5'(sel[i]);
            wait_pulse(600, n);
            wait_pulse(600, n);
            wait_pulse(600, n);
            checks++;
            if (n !== period[i]) begin
                errors++; $display("FAIL div_period sel=%0d: got %0d exp %0d", sel[i], n, period[i]);
            end
        end
    endtask

    task automatic test_step_debounce;
        int lv[10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
        int ln[10] = '{5, 3, 10, 2, 12, 4, 40, 40, 8, 30};
        int pulses_a = 0, pulses_b = 0, first_at = -1;
        logic [15:0] c0;
        mode = 2'b11; btn = 0;
        cyc(30);
        c0 = cnt;
        for (int s = 0; s < 10; s++) begin
            btn = lv[s][0];
            for (int j = 0; j < ln[s]; j++) begin
                cyc(1);
                if (en) begin
                    if (s < 8) pulses_a++; else pulses_b++;
                    if (s == 6 && first_at < 0) first_at = j + 1;
                end
            end
        end
        checks++; if (pulses_a !== 1)  begin errors++; $display("FAIL dbnc_pulses: got %0d exp 1", pulses_a); end
        checks++; if (first_at !== 19) begin errors++; $display("FAIL dbnc_latency: got %0d exp 19", first_at); end
        checks++; if (pulses_b !== 0)  begin errors++; $display("FAIL dbnc_short: got %0d exp 0", pulses_b); end
        checks++; if (cnt !== c0 + 16'd1) begin errors++; $display("FAIL dbnc_cnt: got %0d exp %0d", cnt, c0 + 16'd1); end
    endtask

    task automatic test_display;
        chsel = 2'd2; cyc(1);
        checks++; if (disp !== 32'hDEADBEEF) begin errors++; $display("FAIL disp_ch2: got %h exp deadbeef", disp); end
        chsel = 2'd0; cyc(1);
        checks++; if (disp !== 32'h01234567) begin errors++; $display("FAIL disp_ch0: got %h exp 01234567", disp); end
        chsel = 2'd3; cyc(1);
        checks++; if (disp !== 32'hCAFEF00D) begin errors++; $display("FAIL disp_ch3: got %h exp cafef00d", disp); end
        chsel = 2'd1; #1;
        checks++; if (disp !== 32'hCAFEF00D) begin errors++; $display("FAIL disp_reg_hold: got %h exp cafef00d", disp); end
        cyc(1);
        checks++; if (disp !== 32'h89ABCDEF) begin errors++; $display("FAIL disp_ch1: got %h exp 89abcdef", disp); end
        chsel3 = 2'd3; cyc(1);
        checks++; if (disp3 !== 32'd0) begin errors++; $display("FAIL disp3_oob: got %h exp 0", disp3); end
        chsel3 = 2'd2; cyc(1);
        checks++; if (disp3 !== 32'h33333333) begin errors++; $display("FAIL disp3_ch2: got %h exp 33333333", disp3); end
        chsel3 = 2'd3; cyc(1);
        checks++; if (disp3 !== 32'd0) begin errors++; $display("FAIL disp3_oob2: got %h exp 0", disp3); end
    endtask

`ifdef DBG_BRK_EN
    task automatic test_breakpoint;
        int p;
        mode = 2'b01; btn = 0; pc = 32'h0F; brk_addr = 32'h10; brk_en = 1;
        cyc(2);
        checks++; if (en !== 1'b1) begin errors++; $display("FAIL brk_pre_en: got %b exp 1", en); end
        pc = 32'h10; cyc(1);
        checks++; if (en !== 1'b0)     begin errors++; $display("FAIL brk_hit_en: got %b exp 0", en); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL brk_hit_halted: got %b exp 1", halted); end
        cyc(3);
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL brk_hold_en: got %b exp 0", en); end
        p = 0; btn = 1;
        for (int i = 0; i < 30; i++) begin cyc(1); if (en) p++; end
        btn = 0;
        for (int i = 0; i < 30; i++) begin cyc(1); if (en) p++; end
        checks++; if (p !== 1)         begin errors++; $display("FAIL brk_step_pulses: got %0d exp 1", p); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL brk_step_halted: got %b exp 1", halted); end
        mode = 2'b11; cyc(1);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL brk_exit_halted: got %b exp 0", halted); end
        mode = 2'b01; cyc(1);
        checks++; if (en !== 1'b1) begin errors++; $display("FAIL brk_no_retrap: got %b exp 1", en); end
        cyc(3);
        checks++; if (en !== 1'b1) begin errors++; $display("FAIL brk_no_retrap2: got %b exp 1", en); end
        pc = 32'h11; cyc(1);
        pc = 32'h10; cyc(1);
        checks++; if (en !== 1'b0 || halted !== 1'b1) begin
            errors++; $display("FAIL brk_rearm: got en=%b halted=%b exp en=0 halted=1", en, halted);
        end
        mode = 2'b00; cyc(2);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL brk_to_halt: got %b exp 1", halted); end
        mode = 2'b01; cyc(1);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL brk_halt_run: got %b exp 0", halted); end
        pc = 32'h20; brk_en = 0;
    endtask
`else
    task automatic test_breakpoint;
        mode = 2'b01; btn = 0; pc = 32'h0F; brk_addr = 32'h10; brk_en = 1;
        cyc(2);
        pc = 32'h10; cyc(1);
        checks++; if (en !== 1'b1)     begin errors++; $display("FAIL nobrk_en: got %b exp 1", en); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL nobrk_halted: got %b exp 0", halted); end
        cyc(3);
        checks++; if (en !== 1'b1 || halted !== 1'b0) begin
            errors++; $display("FAIL nobrk_hold: got en=%b halted=%b exp en=1 halted=0", en, halted);
        end
        pc = 32'h20; brk_en = 0;
    endtask
`endif

    task automatic test_wrap;
        rst = 1; mode = 2'b01; brk_en = 0; pc = 0;
        cyc(1);
        rst = 0; cyc(1);
        checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL wrap_start: got %h exp 0", cnt); end
        cyc(65535);
        checks++; if (cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h exp ffff", cnt); end
        cyc(1);
        checks++; if (cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h exp 0000", cnt); end
        checks++; if (en !== 1'b1) begin errors++; $display("FAIL wrap_en: got %b exp 1", en); end
    endtask

    task automatic test_reset_mid;
        int p;
        chsel = 2'd2; cyc(2);
        rst = 1; cyc(1);
        checks++; if (en !== 1'b0 || halted !== 1'b1 || cnt !== 16'd0 || disp !== 32'd0) begin
            errors++; $display("FAIL midrst_outs: got en=%b halted=%b cnt=%h disp=%h exp 0 1 0 0", en, halted, cnt, disp);
        end
        rst = 0; cyc(1);
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL midrst_after_en: got %b exp 0", en); end
        mode = 2'b11; cyc(2);
        btn = 1; cyc(18);
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL midrst_pre_pulse: got %b exp 0", en); end
        rst = 1; btn = 0; cyc(1);
        rst = 0; p = 0;
        for (int i = 0; i < 40; i++) begin cyc(1); if (en) p++; end
        checks++; if (p !== 0)       begin errors++; $display("FAIL midrst_discard: got %0d exp 0", p); end
        checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL midrst_cnt: got %0d exp 0", cnt); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        test_reset();
        test_full_speed();
        test_divided();
        test_step_debounce();
        test_display();
        test_breakpoint();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
